bru_pipe: RTL and testbench

Pipelined, parametrised branch resolution unit for the NPC execute stage. It evaluates the branch condition and computes the branch/jump target in one pass, compares the result against the front-end prediction, and holds the answer in a single output register. Input and output use valid/ready handshakes. It emits a redirect (mispredict) indication to fetch and keeps saturating branch and mispredict performance counters.

---
 rtl/bru_pkg.sv | 15 +
 rtl/bru_cmp.sv | 36 +++
 rtl/bru_pipe.sv | 137 +++++++++++++
 tb/tb_bru_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - branch type encodings and PC step for the branch resolution unit
package bru_pkg;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_JUMP = 3'b001;
   localparam logic [2:0] BR_EQ   = 3'b010;
   localparam logic [2:0] BR_NE   = 3'b011;
   localparam logic [2:0] BR_LT   = 3'b100;
   localparam logic [2:0] BR_GE   = 3'b101;
   localparam logic [2:0] BR_LTU  = 3'b110;
   localparam logic [2:0] BR_GEU  = 3'b111;

   localparam int unsigned BRU_PC_INC = 4;

endpackage

// File: rtl/bru_cmp.sv
// rtl/bru_cmp.sv - combinational branch condition evaluator
module bru_cmp
   import bru_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [2:0]      type_i,
   output logic            taken_o
);

   logic eq;
   logic lt;
   logic ltu;

   assign eq  = (rs1_i == rs2_i);
   assign lt  = ($signed(rs1_i) < $signed(rs2_i));
   assign ltu = (rs1_i < rs2_i);

   always_comb begin
      taken_o = 1'b0;
      case (type_i)
         BR_NONE: taken_o = 1'b0;
         BR_JUMP: taken_o = 1'b1;
         BR_EQ:   taken_o = eq;
         BR_NE:   taken_o = !eq;
         BR_LT:   taken_o = lt;
         BR_GE:   taken_o = !lt;
         BR_LTU:  taken_o = ltu;
         BR_GEU:  taken_o = !ltu;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/bru_pipe.sv
// rtl/bru_pipe.sv - branch resolution unit with single output register and perf counters
module bru_pipe
   import bru_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [2:0]       in_type,
   input  logic             in_jalr,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_next_pc,
   output logic             out_mispredict,
   output logic             out_misalign,
   input  logic             perf_clr,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_mispredicts
);

   logic            taken;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] next_pc;
   logic            mispredict;
   logic            misalign;
   logic            accept;
   logic            out_hs;

   logic             valid_q,   valid_d;
   logic             taken_q,   taken_d;
   logic [XLEN-1:0]  next_pc_q, next_pc_d;
   logic             mispr_q,   mispr_d;
   logic             misal_q,   misal_d;
   logic             is_br_q,   is_br_d;
   logic [CNT_W-1:0] br_cnt_q,  br_cnt_d;
   logic [CNT_W-1:0] mp_cnt_q,  mp_cnt_d;

   bru_cmp #(.XLEN(XLEN)) u_cmp (
      .rs1_i   (in_rs1),
      .rs2_i   (in_rs2),
      .type_i  (in_type),
      .taken_o (taken)
   );

   // Indirect jumps drop bit 0 of the computed target.
   assign base    = in_jalr ? in_rs1 : in_pc;
   assign sum     = base + in_imm;
   assign target  = {sum[XLEN-1:1], sum[0] & ~in_jalr};
   assign seq_pc  = in_pc + XLEN'(BRU_PC_INC);
   assign next_pc = taken ? target : seq_pc;

   assign mispredict = (taken != in_pred_taken) ||
                       (taken && in_pred_taken && (target != in_pred_target));
   assign misalign   = taken && (next_pc[1:0] != 2'b00);

   assign in_ready = !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = valid_q && out_ready;

   always_comb begin
      valid_d   = valid_q;
      taken_d   = taken_q;
      next_pc_d = next_pc_q;
      mispr_d   = mispr_q;
      misal_d   = misal_q;
      is_br_d   = is_br_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         taken_d   = taken;
         next_pc_d = next_pc;
         mispr_d   = mispredict;
         misal_d   = misalign;
         is_br_d   = (in_type != BR_NONE);
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      br_cnt_d = br_cnt_q;
      mp_cnt_d = mp_cnt_q;
      if (perf_clr) begin
         br_cnt_d = '0;
         mp_cnt_d = '0;
      end else if (out_hs && is_br_q) begin
         if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
         if (mispr_q && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         taken_q   <= 1'b0;
         next_pc_q <= '0;
         mispr_q   <= 1'b0;
         misal_q   <= 1'b0;
         is_br_q   <= 1'b0;
         br_cnt_q  <= '0;
         mp_cnt_q  <= '0;
      end else begin
         valid_q   <= valid_d;
         taken_q   <= taken_d;
         next_pc_q <= next_pc_d;
         mispr_q   <= mispr_d;
         misal_q   <= misal_d;
         is_br_q   <= is_br_d;
         br_cnt_q  <= br_cnt_d;
         mp_cnt_q  <= mp_cnt_d;
      end
   end

   assign out_valid        = valid_q;
   assign out_taken        = taken_q;
   assign out_next_pc      = next_pc_q;
   assign out_mispredict   = mispr_q;
   assign out_misalign     = misal_q;
   assign perf_branches    = br_cnt_q;
   assign perf_mispredicts = mp_cnt_q;

endmodule

// File: tb/tb_bru_pipe.sv
// tb/tb_bru_pipe.sv - directed self-checking bench for bru_pipe
module tb_bru_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        in_ready4;
   logic [31:0] in_pc, in_rs1, in_rs2, in_imm, in_pred_target;
   logic [2:0]  in_type;
   logic        in_jalr, in_pred_taken;
   logic        out_valid, out_ready, out_taken, out_mispredict, out_misalign;
   logic [31:0] out_next_pc;
   logic        perf_clr;
   logic [31:0] perf_branches, perf_mispredicts;
   logic        v4, t4, mp4, ma4;
   logic [31:0] np4;
   logic [3:0]  pb4, pm4;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   bru_pipe #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_type(in_type),
      .in_jalr(in_jalr), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_next_pc(out_next_pc), .out_mispredict(out_mispredict), .out_misalign(out_misalign),
      .perf_clr(perf_clr), .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   bru_pipe #(.XLEN(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_type(in_type),
      .in_jalr(in_jalr), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(v4), .out_ready(out_ready), .out_taken(t4),
      .out_next_pc(np4), .out_mispredict(mp4), .out_misalign(ma4),
      .perf_clr(perf_clr), .perf_branches(pb4), .perf_mispredicts(pm4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [2:0] ty, input logic jalr,
                        input logic pt, input logic [31:0] ptgt);
      in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_type = ty;
      in_jalr = jalr; in_pred_taken = pt; in_pred_target = ptgt; in_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; perf_clr = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0);
      in_valid = 1'b0;
      tick(); tick();
      cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      cmp_cnt++; if (out_next_pc !== 32'h0 || out_taken !== 1'b0) begin err_cnt++; $display("FAIL rst_data got %h/%b exp 0/0", out_next_pc, out_taken); end
      cmp_cnt++; if (out_mispredict !== 1'b0 || out_misalign !== 1'b0) begin err_cnt++; $display("FAIL rst_flags got %b/%b exp 0/0", out_mispredict, out_misalign); end
      cmp_cnt++; if (perf_branches !== 32'h0 || perf_mispredicts !== 32'h0) begin err_cnt++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", perf_branches, perf_mispredicts); end
      rst_n = 1'b1;
      tick();
      cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_beq();
      drive(32'h100, 32'd5, 32'd5, 32'h20, 3'b010, 1'b0, 1'b1, 32'h120);
      tick();
      in_valid = 1'b0;
      cmp_cnt++; if (out_valid !== 1'b1 || out_taken !== 1'b1) begin err_cnt++; $display("FAIL beq_vt got %b/%b exp 1/1", out_valid, out_taken); end
      cmp_cnt++; if (out_next_pc !== 32'h120) begin err_cnt++; $display("FAIL beq_npc got %h exp 120", out_next_pc); end
      cmp_cnt++; if (out_mispredict !== 1'b0) begin err_cnt++; $display("FAIL beq_mp got %b exp 0", out_mispredict); end
      tick();
      cmp_cnt++; if (perf_branches !== 32'd1 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL beq_cnt got %0d/%b exp 1/0", perf_branches, out_valid); end
   endtask

   task automatic test_signed_unsigned();
      drive(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'b100, 1'b0, 1'b1, 32'h210);
      tick();
      cmp_cnt++; if (out_taken !== 1'b1 || out_next_pc !== 32'h210 || out_mispredict !== 1'b0) begin err_cnt++; $display("FAIL blt got %b/%h/%b exp 1/210/0", out_taken, out_next_pc, out_mispredict); end
      drive(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'b110, 1'b0, 1'b1, 32'h210);
      tick();
      in_valid = 1'b0;
      cmp_cnt++; if (out_taken !== 1'b0 || out_next_pc !== 32'h204 || out_mispredict !== 1'b1) begin err_cnt++; $display("FAIL bltu got %b/%h/%b exp 0/204/1", out_taken, out_next_pc, out_mispredict); end
      tick();
      cmp_cnt++; if (perf_branches !== 32'd3 || perf_mispredicts !== 32'd1) begin err_cnt++; $display("FAIL bltu_cnt got %0d/%0d exp 3/1", perf_branches, perf_mispredicts); end
   endtask

   task automatic test_jumps();
      drive(32'h300, 32'h1001, 32'h0, 32'h4, 3'b001, 1'b1, 1'b1, 32'h1004);
      tick();
      cmp_cnt++; if (out_next_pc !== 32'h1004 || out_mispredict !== 1'b0 || out_misalign !== 1'b0) begin err_cnt++; $display("FAIL jalr got %h/%b/%b exp 1004/0/0", out_next_pc, out_mispredict, out_misalign); end
      drive(32'h0, 32'h0, 32'h0, 32'h6, 3'b001, 1'b0, 1'b1, 32'h6);
      tick();
      in_valid = 1'b0;
      cmp_cnt++; if (out_next_pc !== 32'h6 || out_misalign !== 1'b1 || out_mispredict !== 1'b0) begin err_cnt++; $display("FAIL jump_mis got %h/%b/%b exp 6/1/0", out_next_pc, out_misalign, out_mispredict); end
      tick();
      cmp_cnt++; if (perf_branches !== 32'd5 || perf_mispredicts !== 32'd1) begin err_cnt++; $display("FAIL jump_cnt got %0d/%0d exp 5/1", perf_branches, perf_mispredicts); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(32'h400, 32'd1, 32'd2, 32'h40, 3'b010, 1'b0, 1'b0, 32'h0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_next_pc !== 32'h404 || out_taken !== 1'b0) begin err_cnt++; $display("FAIL bp_hold%0d got v%b r%b %h t%b exp v1 r0 404 t0", i, out_valid, in_ready, out_next_pc, out_taken); end
         cmp_cnt++; if (perf_branches !== 32'd5) begin err_cnt++; $display("FAIL bp_cnt%0d got %0d exp 5", i, perf_branches); end
      end
      out_ready = 1'b1;
      drive(32'h500, 32'd1, 32'd2, 32'h40, 3'b011, 1'b0, 1'b0, 32'h0);
      #1;
      cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      cmp_cnt++; if (out_next_pc !== 32'h540 || out_mispredict !== 1'b1 || perf_branches !== 32'd6) begin err_cnt++; $display("FAIL b2b got %h/%b/%0d exp 540/1/6", out_next_pc, out_mispredict, perf_branches); end
      tick();
      cmp_cnt++; if (perf_branches !== 32'd7 || perf_mispredicts !== 32'd2) begin err_cnt++; $display("FAIL b2b_cnt got %0d/%0d exp 7/2", perf_branches, perf_mispredicts); end
   endtask

   task automatic test_flush_clr();
      out_ready = 1'b0;
      drive(32'h600, 32'd3, 32'd3, 32'h8, 3'b010, 1'b0, 1'b1, 32'h608);
      tick();
      flush = 1'b1;
      drive(32'h700, 32'h0, 32'h0, 32'h10, 3'b001, 1'b0, 1'b1, 32'h710);
      #1;
      cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL flush_ready got %b exp 0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      cmp_cnt++; if (out_valid !== 1'b0 || out_next_pc !== 32'h608) begin err_cnt++; $display("FAIL flush_kill got %b/%h exp 0/608", out_valid, out_next_pc); end
      tick();
      cmp_cnt++; if (out_valid !== 1'b0 || perf_branches !== 32'd7 || perf_mispredicts !== 32'd2) begin err_cnt++; $display("FAIL flush_cnt got %b/%0d/%0d exp 0/7/2", out_valid, perf_branches, perf_mispredicts); end
      out_ready = 1'b1;
      drive(32'h800, 32'h0, 32'h0, 32'h10, 3'b001, 1'b0, 1'b0, 32'h0);
      tick();
      in_valid = 1'b0; perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      cmp_cnt++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0 || pb4 !== 4'd0) begin err_cnt++; $display("FAIL clr got %0d/%0d/%0d exp 0/0/0", perf_branches, perf_mispredicts, pb4); end
   endtask

   task automatic test_saturation();
      drive(32'h900, 32'd1, 32'd2, 32'h8, 3'b010, 1'b0, 1'b1, 32'h908);
      for (int i = 0; i < 16; i++) tick();
      in_valid = 1'b0;
      tick();
      cmp_cnt++; if (pb4 !== 4'hF || pm4 !== 4'hF) begin err_cnt++; $display("FAIL sat4 got %h/%h exp f/f", pb4, pm4); end
      cmp_cnt++; if (perf_branches !== 32'd16 || perf_mispredicts !== 32'd16) begin err_cnt++; $display("FAIL sat32 got %0d/%0d exp 16/16", perf_branches, perf_mispredicts); end
   endtask

   task automatic test_none_wrap();
      drive(32'hFFFF_FFFC, 32'd1, 32'd1, 32'h20, 3'b000, 1'b0, 1'b0, 32'h0);
      tick();
      cmp_cnt++; if (out_next_pc !== 32'h0 || out_taken !== 1'b0 || out_mispredict !== 1'b0 || out_misalign !== 1'b0) begin err_cnt++; $display("FAIL none_wrap got %h/%b/%b/%b exp 0/0/0/0", out_next_pc, out_taken, out_mispredict, out_misalign); end
      drive(32'h0A00, 32'd1, 32'd1, 32'h20, 3'b000, 1'b0, 1'b1, 32'h0A20);
      tick();
      in_valid = 1'b0;
      cmp_cnt++; if (out_mispredict !== 1'b1 || out_next_pc !== 32'h0A04) begin err_cnt++; $display("FAIL none_mp got %b/%h exp 1/a04", out_mispredict, out_next_pc); end
      tick();
      cmp_cnt++; if (perf_branches !== 32'd16 || perf_mispredicts !== 32'd16) begin err_cnt++; $display("FAIL none_cnt got %0d/%0d exp 16/16", perf_branches, perf_mispredicts); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(32'hB00, 32'h0, 32'h0, 32'h10, 3'b001, 1'b0, 1'b1, 32'hB10);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      cmp_cnt++; if (out_valid !== 1'b0 || out_next_pc !== 32'h0 || perf_branches !== 32'd0) begin err_cnt++; $display("FAIL rst_mid got %b/%h/%0d exp 0/0/0", out_valid, out_next_pc, perf_branches); end
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      cmp_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_rel got %b/%b exp 1/0", in_ready, out_valid); end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_signed_unsigned();
      test_jumps();
      test_backpressure();
      test_flush_clr();
      test_saturation();
      test_none_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
